multicycle_control_fsm: RTL
===========================

Name: multicycle_control_fsm

Overview:
- Multicycle control unit sequencer for the MIPS datapath.
- Drives fetch, decode, execute and writeback states, and emits per-state datapath strobes and selects.
- At DECODE it consumes the 7-bit state code from the instruction-to-state encoder (State_Sel). It then jumps directly to that execute state.
- Handshakes with memory through mem_req / moc.

Parameters:
- TIMEOUT_CYCLES, 255: maximum wait-state cycles before a memory fault. Used only with MOC_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- state_sel  input  7  encoder next-state code. Legal codes: 6, 7, 11, 13, 17-22. Code 0 means illegal.
- moc  input  1  memory operation complete.
- cond  input  1  ALU zero flag, used for BEQ.
- state  output  7  current state register.
- pc_ld, ir_ld, mar_ld, mdr_ld, rf_ld  output  1 each  register load strobes.
- mem_req  output  1  memory access active.
- mem_rw  output  1  1 = read, 0 = write.
- alu_op  output  4  0 PASS_A, 1 ADD, 2 SUB, 3 SLTU, 4 CLO, 5 CLZ.
- srcb_sel  output  2  0 rt, 1 const 4, 2 sign-extended imm, 3 imm<<2.
- rf_dst_sel  output  1  0 rt, 1 rd.
- rf_src_sel  output  1  0 ALU, 1 MDR.
- mdr_src_sel  output  1  0 memory, 1 rt.
- pc_src_sel  output  1  0 ALU (PC+4), 1 branch target.
- illegal  output  1  sticky illegal-opcode flag.
- mem_fault  output  1  sticky timeout flag. Constant 0 without MOC_TIMEOUT_EN.

Behaviour:
- Moore machine: all strobes and selects decode from the registered state. Only next-state logic reads inputs.
- Reset: on any edge with reset=1, state becomes 0 and illegal/mem_fault clear. This applies from every state, including memory wait states. While in state 0 every output is 0 (alu_op=0, selects=0).
- State 0 RESET -> 1.
- State 1 FETCH_ADDR: mar_ld, alu_op PASS_A. -> 2.
- State 2 FETCH_READ: mem_req, mem_rw=1, mdr_ld, mdr_src_sel=0.
  - Hold while moc=0; go to 3 on the first edge with moc=1.
- State 3 FETCH_IR: ir_ld. -> 4.
- State 4 PC_INC: pc_ld, alu_op ADD, srcb_sel=1, pc_src_sel=0. -> 5.
- State 5 DECODE: no strobes.
  - Next state = state_sel when the code is legal.
  - Otherwise set illegal and go to 1; the instruction is skipped.
- States 6/17/18/19/20/21/22 (ADDU/SUBU/ADDIU/SLTU/SLTIU/CLO/CLZ): rf_ld, rf_src_sel=0, then -> 1.
  - alu_op: ADD/SUB/ADD/SLTU/SLTU/CLO/CLZ respectively.
  - srcb_sel=2 for 18 and 20; 0 otherwise.
  - rf_dst_sel=0 for 18 and 20; 1 otherwise.
- Store sequence (covers SB/SH/SW):
  - State 7 STORE_ADDR: mar_ld, ADD, srcb=2. -> 8.
  - State 8 STORE_DATA: mdr_ld, mdr_src_sel=1. -> 9.
  - State 9 STORE_WRITE: mem_req, mem_rw=0; hold until moc=1, then -> 1.
- Branch sequence:
  - State 11 BEQ_CMP: SUB, srcb=0. If cond=1 -> 12, else -> 1.
  - State 12 BEQ_TAKE: pc_ld, ADD, srcb=3, pc_src_sel=1. -> 1.
- Load sequence:
  - State 13 LOAD_ADDR: mar_ld, ADD, srcb=2. -> 14.
  - State 14 LOAD_READ: mem_req, mem_rw=1, mdr_ld; hold until moc=1, then -> 15.
  - State 15 LOAD_WB: rf_ld, rf_src_sel=1, rf_dst_sel=0. -> 1.
- Any unassigned state value (including 10 and 16) -> 0 on the next edge.
- moc outside wait states 2/9/14 is ignored.
- moc is sampled only while in a wait state, so minimum wait-state residency is 1 cycle. moc high on the entry edge does not skip the state.
- Latency with moc=1 immediately:
  - ALU instruction: 6 cycles (1-2-3-4-5-X).
  - Load: 8 cycles.
  - Store: 8 cycles.
  - BEQ: 6 cycles not taken, 7 taken.
- illegal and mem_fault clear only on reset.

Optional Feature:
- Macro: MOC_TIMEOUT_EN.
- When defined:
  - An 8+-bit wait counter clears on every entry to states 2/9/14 and increments each cycle spent in them.
  - When the counter reaches TIMEOUT_CYCLES with moc still 0, mem_fault is set and the next state is 0.
  - moc=1 on the same cycle as the count reaching the limit wins: normal transition, no fault.
- When undefined: no counter, mem_fault tied to 0, wait states hold indefinitely.

Test Plan:
- Reset, release, moc=1 always, state_sel=6 -> states 0,1,2,3,4,5,6,1. rf_ld=1 only in state 6, with alu_op=1 and rf_dst_sel=1.
- Load with moc delayed 3 cycles in state 14 -> state 14 held for 4 cycles, mdr_ld high throughout. Then 15 with rf_src_sel=1, then 1.
- BEQ, cond=1 -> 11,12,1, with pc_ld and pc_src_sel=1 in state 12. BEQ, cond=0 -> 11,1 with no pc_ld.
- state_sel=0 at DECODE -> illegal=1, next state 1. Next instruction fetches normally and illegal stays 1 until reset.
- reset asserted in state 9 with mem_req=1 -> next cycle state 0, all outputs 0, flags cleared.
- With MOC_TIMEOUT_EN and TIMEOUT_CYCLES=4, moc held 0 in state 2 -> mem_fault=1 and state 0 after 4 cycles. Repeat with moc=1 on the 4th cycle -> state 3, mem_fault=0.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS control sequencer: fetch/decode/execute/writeback with Moore-decoded datapath strobes.
// Optional memory wait-state timeout enabled by defining MOC_TIMEOUT_EN.
module multicycle_control_fsm #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] state_sel,
  input  logic       moc,
  input  logic       cond,
  output logic [6:0] state,
  output logic       pc_ld,
  output logic       ir_ld,
  output logic       mar_ld,
  output logic       mdr_ld,
  output logic       rf_ld,
  output logic       mem_req,
  output logic       mem_rw,
  output logic [3:0] alu_op,
  output logic [1:0] srcb_sel,
  output logic       rf_dst_sel,
  output logic       rf_src_sel,
  output logic       mdr_src_sel,
  output logic       pc_src_sel,
  output logic       illegal,
  output logic       mem_fault
);

  typedef enum logic [6:0] {
    S_RESET       = 7'd0,
    S_FETCH_ADDR  = 7'd1,
    S_FETCH_READ  = 7'd2,
    S_FETCH_IR    = 7'd3,
    S_PC_INC      = 7'd4,
    S_DECODE      = 7'd5,
    S_ADDU        = 7'd6,
    S_STORE_ADDR  = 7'd7,
    S_STORE_DATA  = 7'd8,
    S_STORE_WRITE = 7'd9,
    S_BEQ_CMP     = 7'd11,
    S_BEQ_TAKE    = 7'd12,
    S_LOAD_ADDR   = 7'd13,
    S_LOAD_READ   = 7'd14,
    S_LOAD_WB     = 7'd15,
    S_SUBU        = 7'd17,
    S_ADDIU       = 7'd18,
    S_SLTU        = 7'd19,
    S_SLTIU       = 7'd20,
    S_CLO         = 7'd21,
    S_CLZ         = 7'd22
  } state_t;

  typedef enum logic [3:0] {
    ALU_PASS_A = 4'd0,
    ALU_ADD    = 4'd1,
    ALU_SUB    = 4'd2,
    ALU_SLTU   = 4'd3,
    ALU_CLO    = 4'd4,
    ALU_CLZ    = 4'd5
  } alu_op_t;

  state_t state_q, state_d;
  logic   illegal_q, illegal_set, sel_legal, timeout_hit;

  assign state   = state_q;
  assign illegal = illegal_q;

  always_comb begin
    sel_legal = 1'b0;
    case (state_sel)
      7'd6, 7'd7, 7'd11, 7'd13, 7'd17, 7'd18, 7'd19, 7'd20, 7'd21, 7'd22: sel_legal = 1'b1;
      default: sel_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = S_RESET;
    illegal_set = 1'b0;
    case (state_q)
      S_RESET:       state_d = S_FETCH_ADDR;
      S_FETCH_ADDR:  state_d = S_FETCH_READ;
      S_FETCH_READ:  state_d = moc ? S_FETCH_IR : S_FETCH_READ;
      S_FETCH_IR:    state_d = S_PC_INC;
      S_PC_INC:      state_d = S_DECODE;
      S_DECODE: begin
        if (sel_legal) begin
          state_d = state_t'(state_sel);
        end else begin
          illegal_set = 1'b1;
          state_d     = S_FETCH_ADDR;
        end
      end
      S_ADDU, S_SUBU, S_ADDIU, S_SLTU, S_SLTIU, S_CLO, S_CLZ: state_d = S_FETCH_ADDR;
      S_STORE_ADDR:  state_d = S_STORE_DATA;
      S_STORE_DATA:  state_d = S_STORE_WRITE;
      S_STORE_WRITE: state_d = moc ? S_FETCH_ADDR : S_STORE_WRITE;
      S_BEQ_CMP:     state_d = cond ? S_BEQ_TAKE : S_FETCH_ADDR;
      S_BEQ_TAKE:    state_d = S_FETCH_ADDR;
      S_LOAD_ADDR:   state_d = S_LOAD_READ;
      S_LOAD_READ:   state_d = moc ? S_LOAD_WB : S_LOAD_READ;
      S_LOAD_WB:     state_d = S_FETCH_ADDR;
      default:       state_d = S_RESET;
    endcase
    if (timeout_hit) state_d = S_RESET;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_RESET;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (illegal_set) illegal_q <= 1'b1;
    end
  end

`ifdef MOC_TIMEOUT_EN
  localparam int unsigned CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CW-1:0] wait_cnt;
  logic          in_wait, mem_fault_q;

  assign in_wait   = (state_q == S_FETCH_READ) || (state_q == S_STORE_WRITE) || (state_q == S_LOAD_READ);
  // wait_cnt counts completed wait cycles, so the limit is hit on the TIMEOUT_CYCLES-th cycle of residency.
  assign timeout_hit = in_wait && !moc && ((int unsigned'(wait_cnt) + 1) >= TIMEOUT_CYCLES);
  assign mem_fault   = mem_fault_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt    <= '0;
      mem_fault_q <= 1'b0;
    end else begin
      if (in_wait && (state_d == state_q)) wait_cnt <= wait_cnt + 1'b1;
      else                                 wait_cnt <= '0;
      if (timeout_hit) mem_fault_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign mem_fault   = 1'b0;

  // TIMEOUT_CYCLES only shapes the optional wait limit; nothing to build when it is absent.
  if (TIMEOUT_CYCLES == 0) begin : g_no_wait_limit
  end
`endif

  always_comb begin
    pc_ld       = 1'b0;
    ir_ld       = 1'b0;
    mar_ld      = 1'b0;
    mdr_ld      = 1'b0;
    rf_ld       = 1'b0;
    mem_req     = 1'b0;
    mem_rw      = 1'b0;
    alu_op      = ALU_PASS_A;
    srcb_sel    = 2'd0;
    rf_dst_sel  = 1'b0;
    rf_src_sel  = 1'b0;
    mdr_src_sel = 1'b0;
    pc_src_sel  = 1'b0;
    case (state_q)
      S_FETCH_ADDR: mar_ld = 1'b1;
      S_FETCH_READ: begin
        mem_req = 1'b1;
        mem_rw  = 1'b1;
        mdr_ld  = 1'b1;
      end
      S_FETCH_IR: ir_ld = 1'b1;
      S_PC_INC: begin
        pc_ld    = 1'b1;
        alu_op   = ALU_ADD;
        srcb_sel = 2'd1;
      end
      S_ADDU, S_SUBU, S_ADDIU, S_SLTU, S_SLTIU, S_CLO, S_CLZ: begin
        rf_ld      = 1'b1;
        rf_dst_sel = 1'b1;
        case (state_q)
          S_SUBU:  alu_op = ALU_SUB;
          S_SLTU:  alu_op = ALU_SLTU;
          S_CLO:   alu_op = ALU_CLO;
          S_CLZ:   alu_op = ALU_CLZ;
          S_ADDIU: begin alu_op = ALU_ADD;  srcb_sel = 2'd2; rf_dst_sel = 1'b0; end
          S_SLTIU: begin alu_op = ALU_SLTU; srcb_sel = 2'd2; rf_dst_sel = 1'b0; end
          default: alu_op = ALU_ADD;
        endcase
      end
      S_STORE_ADDR, S_LOAD_ADDR: begin
        mar_ld   = 1'b1;
        alu_op   = ALU_ADD;
        srcb_sel = 2'd2;
      end
      S_STORE_DATA: begin
        mdr_ld      = 1'b1;
        mdr_src_sel = 1'b1;
      end
      S_STORE_WRITE: mem_req = 1'b1;
      S_BEQ_CMP: alu_op = ALU_SUB;
      S_BEQ_TAKE: begin
        pc_ld      = 1'b1;
        alu_op     = ALU_ADD;
        srcb_sel   = 2'd3;
        pc_src_sel = 1'b1;
      end
      S_LOAD_READ: begin
        mem_req = 1'b1;
        mem_rw  = 1'b1;
        mdr_ld  = 1'b1;
      end
      S_LOAD_WB: begin
        rf_ld      = 1'b1;
        rf_src_sel = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
